// File: rtl/load_store_buffer.sv
// In-order load/store buffer: memory ops wait for operands, then issue strictly from the head.
// Latency: a ready load at the head is registered onto res_* one cycle later; stores write combinationally when committed.
// Backpressure: full_o blocks dispatch; a held result (res_grant_i=0) stalls the next load at the head.
//
// Ports:
//   clk_i, rst_i (sync, active-high), rollback_i (flush all in-flight ops)
//   disp_*_i   : dispatch of one memory op (operands as value or ROB tag + busy)
//   full_o     : no free entry (from registered count)
//   cdb_*_i    : common data bus snoop for operand wakeup
//   rob_head_* : ROB head, gates the store write
//   mem_*      : word memory port, mem_rdata_i is a combinational read of mem_addr_o
//   res_*      : load result towards the CDB arbiter, held until res_grant_i
// Optional: define LSB_PERF_CNT_EN to add perf_loads_o / perf_stores_o / perf_full_stall_o.
module load_store_buffer #(
    parameter int DEPTH = 4,
    parameter int ROB_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             rollback_i,
    input  logic             disp_we_i,
    input  logic             disp_is_store_i,
    input  logic [2:0]       disp_rdctrl_i,
    input  logic [1:0]       disp_wrctrl_i,
    input  logic [31:0]      disp_vj_i,
    input  logic [ROB_W-1:0] disp_qj_i,
    input  logic             disp_qj_busy_i,
    input  logic [31:0]      disp_vk_i,
    input  logic [ROB_W-1:0] disp_qk_i,
    input  logic             disp_qk_busy_i,
    input  logic [31:0]      disp_imm_i,
    input  logic [ROB_W-1:0] disp_dest_i,
    output logic             full_o,
    input  logic             cdb_valid_i,
    input  logic [ROB_W-1:0] cdb_tag_i,
    input  logic [31:0]      cdb_data_i,
    input  logic             rob_head_valid_i,
    input  logic [ROB_W-1:0] rob_head_idx_i,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    output logic             mem_we_o,
    output logic [1:0]       mem_wctrl_o,
    input  logic [31:0]      mem_rdata_i,
    output logic             res_valid_o,
    output logic [ROB_W-1:0] res_tag_o,
    output logic [31:0]      res_data_o,
    input  logic             res_grant_i
`ifdef LSB_PERF_CNT_EN
    ,
    output logic [31:0]      perf_loads_o,
    output logic [31:0]      perf_stores_o,
    output logic [31:0]      perf_full_stall_o
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic             vld;
        logic             is_st;
        logic [2:0]       rdctrl;
        logic [1:0]       wrctrl;
        logic [31:0]      vj;
        logic [ROB_W-1:0] qj;
        logic             qj_busy;
        logic [31:0]      vk;
        logic [ROB_W-1:0] qk;
        logic             qk_busy;
        logic [31:0]      imm;
        logic [ROB_W-1:0] dest;
    } ent_t;

    ent_t             ent_q [DEPTH];
    ent_t             ent_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             res_vld_q, res_vld_d;
    logic [ROB_W-1:0] res_tag_q, res_tag_d;
    logic [31:0]      res_dat_q, res_dat_d;

    ent_t hd;
    ent_t new_e;
    logic ld_fire, st_fire, enq, deq;

    // Pick byte/half out of the addressed word and extend; unknown codes fall back to a word load.
    function automatic logic [31:0] ld_extract(input logic [2:0] ctrl, input logic [1:0] off,
                                               input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (ctrl)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'b0, b};
            3'b101:  return {16'b0, h};
            default: return w;
        endcase
    endfunction

    assign hd         = ent_q[head_q];
    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign mem_addr_o = hd.vj + hd.imm;

    // The result register may be reloaded in the same cycle it is being granted.
    assign ld_fire = hd.vld & ~hd.is_st & ~hd.qj_busy & (~res_vld_q | res_grant_i)
                   & ~rollback_i & ~rst_i;
    // Stores only commit once the ROB has retired everything older than them.
    assign st_fire = hd.vld & hd.is_st & ~hd.qj_busy & ~hd.qk_busy & rob_head_valid_i
                   & (rob_head_idx_i == hd.dest) & ~rollback_i & ~rst_i;
    assign deq     = ld_fire | st_fire;
    assign enq     = disp_we_i & ~full_o & ~rollback_i;

    assign mem_we_o    = st_fire;
    assign mem_wdata_o = hd.vk;
    assign mem_wctrl_o = hd.wrctrl;

    assign res_valid_o = res_vld_q;
    assign res_tag_o   = res_tag_q;
    assign res_data_o  = res_dat_q;

    // Incoming entry, with a same-cycle CDB broadcast folded in so it never misses its wakeup.
    always_comb begin
        new_e         = '0;
        new_e.vld     = 1'b1;
        new_e.is_st   = disp_is_store_i;
        new_e.rdctrl  = disp_rdctrl_i;
        new_e.wrctrl  = disp_wrctrl_i;
        new_e.vj      = disp_vj_i;
        new_e.qj      = disp_qj_i;
        new_e.qj_busy = disp_qj_busy_i;
        new_e.vk      = disp_vk_i;
        new_e.qk      = disp_qk_i;
        new_e.qk_busy = disp_qk_busy_i;
        new_e.imm     = disp_imm_i;
        new_e.dest    = disp_dest_i;
        if (cdb_valid_i && disp_qj_busy_i && (disp_qj_i == cdb_tag_i)) begin
            new_e.vj      = cdb_data_i;
            new_e.qj_busy = 1'b0;
        end
        if (cdb_valid_i && disp_qk_busy_i && (disp_qk_i == cdb_tag_i)) begin
            new_e.vk      = cdb_data_i;
            new_e.qk_busy = 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            if (ent_q[i].vld && cdb_valid_i) begin
                if (ent_q[i].qj_busy && (ent_q[i].qj == cdb_tag_i)) begin
                    ent_d[i].vj      = cdb_data_i;
                    ent_d[i].qj_busy = 1'b0;
                end
                if (ent_q[i].qk_busy && (ent_q[i].qk == cdb_tag_i)) begin
                    ent_d[i].vk      = cdb_data_i;
                    ent_d[i].qk_busy = 1'b0;
                end
            end
        end
        // head and tail cannot coincide here: enq needs a free slot, deq needs a valid head.
        if (deq) ent_d[head_q].vld = 1'b0;
        if (enq) ent_d[tail_q] = new_e;

        head_d  = deq ? head_q + PTR_W'(1) : head_q;
        tail_d  = enq ? tail_q + PTR_W'(1) : tail_q;
        count_d = count_q + CNT_W'(enq) - CNT_W'(deq);

        res_vld_d = res_vld_q;
        res_tag_d = res_tag_q;
        res_dat_d = res_dat_q;
        if (ld_fire) begin
            res_vld_d = 1'b1;
            res_tag_d = hd.dest;
            res_dat_d = ld_extract(hd.rdctrl, mem_addr_o[1:0], mem_rdata_i);
        end else if (res_grant_i) begin
            res_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            res_vld_q <= 1'b0;
            res_tag_q <= '0;
            res_dat_q <= '0;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
        end else if (rollback_i) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            res_vld_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) ent_q[i].vld <= 1'b0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            res_vld_q <= res_vld_d;
            res_tag_q <= res_tag_d;
            res_dat_q <= res_dat_d;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
        end
    end

`ifdef LSB_PERF_CNT_EN
    logic [31:0] perf_ld_q, perf_st_q, perf_stall_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_ld_q    <= '0;
            perf_st_q    <= '0;
            perf_stall_q <= '0;
        end else begin
            if (res_vld_q && res_grant_i) perf_ld_q    <= perf_ld_q + 32'd1;
            if (st_fire)                  perf_st_q    <= perf_st_q + 32'd1;
            if (disp_we_i && full_o)      perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_loads_o      = perf_ld_q;
    assign perf_stores_o     = perf_st_q;
    assign perf_full_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_load_store_buffer.sv
// Bench for load_store_buffer: directed scenarios followed by randomized traffic.
// Latency: every step is one clock; outputs are sampled 1ns after the falling edge.
// Backpressure: res_grant and rob_head are driven by the bench to exercise stalls.
module tb_load_store_buffer;

    localparam int DEPTH = 4;
    localparam int ROB_W = 3;

    logic        clk = 1'b0;
    logic        rst, rollback;
    logic        disp_we, disp_is_store, disp_qj_busy, disp_qk_busy;
    logic [2:0]  disp_rdctrl;
    logic [1:0]  disp_wrctrl;
    logic [31:0] disp_vj, disp_vk, disp_imm;
    logic [2:0]  disp_qj, disp_qk, disp_dest;
    logic        full;
    logic        cdb_valid;
    logic [2:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        rob_head_valid;
    logic [2:0]  rob_head_idx;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;
    logic [1:0]  mem_wctrl;
    logic        res_valid, res_grant;
    logic [2:0]  res_tag;
    logic [31:0] res_data;
`ifdef LSB_PERF_CNT_EN
    logic [31:0] perf_loads, perf_stores, perf_full_stall;
`endif

    always #5 clk = ~clk;

    load_store_buffer #(.DEPTH(DEPTH), .ROB_W(ROB_W)) dut (
        .clk_i(clk), .rst_i(rst), .rollback_i(rollback),
        .disp_we_i(disp_we), .disp_is_store_i(disp_is_store), .disp_rdctrl_i(disp_rdctrl),
        .disp_wrctrl_i(disp_wrctrl), .disp_vj_i(disp_vj), .disp_qj_i(disp_qj),
        .disp_qj_busy_i(disp_qj_busy), .disp_vk_i(disp_vk), .disp_qk_i(disp_qk),
        .disp_qk_busy_i(disp_qk_busy), .disp_imm_i(disp_imm), .disp_dest_i(disp_dest),
        .full_o(full), .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag), .cdb_data_i(cdb_data),
        .rob_head_valid_i(rob_head_valid), .rob_head_idx_i(rob_head_idx),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_we_o(mem_we),
        .mem_wctrl_o(mem_wctrl), .mem_rdata_i(mem_rdata),
        .res_valid_o(res_valid), .res_tag_o(res_tag), .res_data_o(res_data),
        .res_grant_i(res_grant)
`ifdef LSB_PERF_CNT_EN
        , .perf_loads_o(perf_loads), .perf_stores_o(perf_stores),
        .perf_full_stall_o(perf_full_stall)
`endif
    );

    // Environment memory (what the DUT sees) and the reference model's own memory.
    logic [31:0] env_mem [256];
    logic [31:0] mdl_mem [256];
    assign mem_rdata = env_mem[mem_addr[9:2]];

    typedef struct {
        logic        st;
        logic [2:0]  rd;
        logic [1:0]  wr;
        logic [31:0] vj, vk, imm;
        logic [2:0]  qj, qk, dest;
        logic        jb, kb;
    } op_t;

    op_t         mq[$];        // ops in program order
    logic        ev;           // expected result register
    logic [2:0]  et;
    logic [31:0] ed;
    int          checks = 0;
    int          failures = 0;

    function automatic logic [31:0] ld_ref(input logic [2:0] c, input logic [31:0] a,
                                           input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * int'(a[1:0]))) & 32'hFF;
        h = (w >> (16 * int'(a[1]))) & 32'hFFFF;
        case (c)
            3'b000:  return b[7]  ? (b | 32'hFFFFFF00) : b;
            3'b001:  return h[15] ? (h | 32'hFFFF0000) : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] a,
                                          input logic [1:0] c, input logic [31:0] d);
        logic [31:0] m;
        int          sh;
        case (c)
            2'b00:   begin sh = 8 * int'(a[1:0]); m = 32'hFF << sh;   end
            2'b01:   begin sh = 16 * int'(a[1]);  m = 32'hFFFF << sh; end
            default: begin sh = 0;                m = 32'hFFFFFFFF;   end
        endcase
        return (old & ~m) | ((d << sh) & m);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst = 0; rollback = 0; disp_we = 0; disp_is_store = 0; disp_rdctrl = 0; disp_wrctrl = 0;
        disp_vj = 0; disp_qj = 0; disp_qj_busy = 0; disp_vk = 0; disp_qk = 0; disp_qk_busy = 0;
        disp_imm = 0; disp_dest = 0; cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
        rob_head_valid = 0; rob_head_idx = 0; res_grant = 1;
    endtask

    task automatic disp(input logic st, input logic [2:0] rd, input logic [1:0] wr,
                        input logic [31:0] vj, input logic [2:0] qj, input logic jb,
                        input logic [31:0] vk, input logic [31:0] imm, input logic [2:0] dest);
        disp_we = 1; disp_is_store = st; disp_rdctrl = rd; disp_wrctrl = wr;
        disp_vj = vj; disp_qj = qj; disp_qj_busy = jb; disp_vk = vk; disp_qk = 0;
        disp_qk_busy = 0; disp_imm = imm; disp_dest = dest;
    endtask

    // One clock: compare DUT against the model, advance the model, clock, update memory.
    task automatic step();
        op_t         f, o;
        logic        fl, fs, we_seen;
        logic [31:0] a, wa, wd;
        logic [1:0]  wc;
        int          n0;
        #1;
        n0 = mq.size();
        fl = 0; fs = 0;
        if (!rst && !rollback && n0 > 0) begin
            f  = mq[0];
            fl = !f.st && !f.jb && (!ev || res_grant);
            fs = f.st && !f.jb && !f.kb && rob_head_valid && (rob_head_idx == f.dest);
        end
        chk("full", 32'(full), 32'(n0 == DEPTH));
        chk("mem_we", 32'(mem_we), 32'(fs));
        if (fs) begin
            chk("st_addr", mem_addr, f.vj + f.imm);
            chk("st_wdata", mem_wdata, f.vk);
            chk("st_wctrl", 32'(mem_wctrl), 32'(f.wr));
        end
        chk("res_valid", 32'(res_valid), 32'(ev));
        if (ev) begin
            chk("res_tag", 32'(res_tag), 32'(et));
            chk("res_data", res_data, ed);
        end
        we_seen = mem_we; wa = mem_addr; wd = mem_wdata; wc = mem_wctrl;
        if (rst || rollback) begin
            mq.delete();
            ev = 0;
        end else begin
            if (fl) begin
                a  = f.vj + f.imm;
                ed = ld_ref(f.rd, a, mdl_mem[a[9:2]]);
                et = f.dest;
                ev = 1;
                void'(mq.pop_front());
            end else if (ev && res_grant) begin
                ev = 0;
            end
            if (fs) begin
                a = f.vj + f.imm;
                mdl_mem[a[9:2]] = merge(mdl_mem[a[9:2]], a, f.wr, f.vk);
                void'(mq.pop_front());
            end
            if (disp_we && n0 < DEPTH) begin
                o.st = disp_is_store; o.rd = disp_rdctrl; o.wr = disp_wrctrl;
                o.vj = disp_vj; o.qj = disp_qj; o.jb = disp_qj_busy;
                o.vk = disp_vk; o.qk = disp_qk; o.kb = disp_qk_busy;
                o.imm = disp_imm; o.dest = disp_dest;
                mq.push_back(o);
            end
            if (cdb_valid) begin
                for (int i = 0; i < mq.size(); i++) begin
                    o = mq[i];
                    if (o.jb && o.qj == cdb_tag) begin o.vj = cdb_data; o.jb = 0; end
                    if (o.kb && o.qk == cdb_tag) begin o.vk = cdb_data; o.kb = 0; end
                    mq[i] = o;
                end
            end
        end
        @(posedge clk);
        if (we_seen) env_mem[wa[9:2]] = merge(env_mem[wa[9:2]], wa, wc, wd);
        @(negedge clk);
    endtask

    // Empty the buffer: wake every tag round-robin and commit stores as they reach the head.
    task automatic drain(input string tag);
        int n;
        idle();
        n = 0;
        while ((mq.size() > 0 || ev) && n < 64) begin
            cdb_valid = 1; cdb_tag = 3'(n); cdb_data = $urandom;
            if (mq.size() > 0 && mq[0].st) begin
                rob_head_valid = 1; rob_head_idx = mq[0].dest;
            end else begin
                rob_head_valid = 0;
            end
            step();
            n++;
        end
        checks++;
        assert (n < 64) else begin
            failures++;
            $error("FAIL %s_timeout cycles=%0d limit=64", tag, n);
        end
        idle();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            env_mem[i] = $urandom;
            mdl_mem[i] = env_mem[i];
        end
        ev = 0; et = 0; ed = 0;
        idle();
        rst = 1;
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst = 0;
        #1;
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_res_tag", 32'(res_tag), 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_mem_we", 32'(mem_we), 0);

        // Word load with ready base.
        env_mem[8'h41] = 32'hDEADBEEF; mdl_mem[8'h41] = 32'hDEADBEEF;
        disp(0, 3'b010, 0, 32'h100, 0, 0, 0, 4, 3);
        step();
        idle();
        #1 chk("lw_before", 32'(res_valid), 0);
        step();
        chk("lw_valid", 32'(res_valid), 1);
        chk("lw_data", res_data, 32'hDEADBEEF);
        chk("lw_tag", 32'(res_tag), 3);
        step();

        // Signed byte load woken by the CDB, then unsigned byte with same-cycle bypass.
        env_mem[8'h80] = 32'h80FF7F01; mdl_mem[8'h80] = 32'h80FF7F01;
        disp(0, 3'b000, 0, 0, 2, 1, 0, 0, 1);
        step();
        idle();
        step(); step();
        chk("lb_waits", 32'(res_valid), 0);
        cdb_valid = 1; cdb_tag = 2; cdb_data = 32'h203;
        step();
        idle();
        step();
        chk("lb_data", res_data, 32'hFFFFFF80);
        step();
        disp(0, 3'b100, 0, 0, 2, 1, 0, 0, 2);
        cdb_valid = 1; cdb_tag = 2; cdb_data = 32'h203;
        step();
        idle();
        step();
        chk("lbu_data", res_data, 32'h00000080);
        chk("lbu_tag", 32'(res_tag), 2);
        step();

        // Store waits for the ROB head, then pulses once; reading it back sees the new word.
        disp(1, 0, 2'b10, 32'h40, 0, 0, 32'h12345678, 0, 5);
        step();
        idle();
        rob_head_valid = 1; rob_head_idx = 4;
        repeat (3) begin
            #1 chk("sw_hold", 32'(mem_we), 0);
            step();
        end
        rob_head_idx = 5;
        #1 chk("sw_pulse", 32'(mem_we), 1);
        chk("sw_wdata", mem_wdata, 32'h12345678);
        step();
        #1 chk("sw_once", 32'(mem_we), 0);
        idle();
        disp(0, 3'b010, 0, 32'h40, 0, 0, 0, 0, 6);
        step();
        idle();
        step();
        chk("sw_readback", res_data, 32'h12345678);
        step();

        // Fill to full; the fifth dispatch is dropped. Then interleaved traffic across the wrap.
        for (int i = 0; i < DEPTH; i++) begin
            disp(0, 3'b010, 0, 32'(i * 4), 7, 1, 0, 0, 3'(i));
            step();
        end
        #1 chk("fill_full", 32'(full), 1);
        disp(0, 3'b010, 0, 0, 0, 0, 0, 0, 4);
        step();
        chk("fifth_ignored_full", 32'(full), 1);
        drain("fill");
        for (int i = 0; i < 10; i++) begin
            disp(0, 3'(($urandom % 2) ? 3'b010 : 3'b101), 0, $urandom, 0, 0, 0,
                 32'($urandom % 16), 3'(i));
            res_grant = 1'($urandom % 2);
            step();
        end
        drain("wrap");

        // Two ready loads with the grant held off.
        res_grant = 0;
        disp(0, 3'b010, 0, 32'h10, 0, 0, 0, 0, 1);
        step();
        disp(0, 3'b010, 0, 32'h20, 0, 0, 0, 0, 2);
        step();
        idle();
        res_grant = 0;
        repeat (4) begin
            chk("hold_tag", 32'(res_tag), 1);
            step();
        end
        res_grant = 1;
        step();
        chk("second_tag", 32'(res_tag), 2);
        step();

        // Rollback with an eligible store at the head and a held result.
        res_grant = 0;
        disp(0, 3'b010, 0, 32'h30, 0, 0, 0, 0, 7);
        step();
        disp(1, 0, 2'b10, 32'h50, 0, 0, 32'hCAFEF00D, 0, 1);
        step();
        disp(0, 3'b000, 0, 0, 6, 1, 0, 0, 2);
        step();
        disp(0, 3'b000, 0, 0, 6, 1, 0, 0, 3);
        step();
        idle();
        res_grant = 0; rollback = 1; rob_head_valid = 1; rob_head_idx = 1;
        #1 chk("rb_mem_we", 32'(mem_we), 0);
        step();
        idle();
        #1 chk("rb_full", 32'(full), 0);
        chk("rb_res_valid", 32'(res_valid), 0);
        step();

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            rst           = ($urandom % 400 == 0);
            rollback      = ($urandom % 80 == 0);
            disp_we       = 1'($urandom % 2);
            disp_is_store = ($urandom % 3 == 0);
            disp_rdctrl   = 3'($urandom);
            disp_wrctrl   = 2'($urandom % 3);
            disp_vj       = $urandom;
            disp_qj       = 3'($urandom);
            disp_qj_busy  = ($urandom % 4 == 0);
            disp_vk       = $urandom;
            disp_qk       = 3'($urandom);
            disp_qk_busy  = ($urandom % 4 == 0);
            disp_imm      = 32'($urandom % 64);
            disp_dest     = 3'($urandom);
            cdb_valid     = ($urandom % 3 == 0);
            cdb_tag       = 3'($urandom);
            cdb_data      = $urandom;
            if (mq.size() > 0 && mq[0].st && ($urandom % 2 == 1)) begin
                rob_head_valid = 1; rob_head_idx = mq[0].dest;
            end else begin
                rob_head_valid = 1'($urandom % 2); rob_head_idx = 3'($urandom);
            end
            res_grant = ($urandom % 4 != 0);
            step();
        end
        drain("random");

        // Reset in the middle of a committable store.
        disp(1, 0, 2'b10, 32'h60, 0, 0, 32'h0BADF00D, 0, 3);
        step();
        idle();
        rst = 1; rob_head_valid = 1; rob_head_idx = 3;
        #1 chk("rst_store_we", 32'(mem_we), 0);
        step();
        idle();
        #1 chk("rst_after_full", 32'(full), 0);
        chk("rst_after_tag", 32'(res_tag), 0);
        chk("rst_after_data", res_data, 0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
